// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: GPIO pad driver with turnaround-gapped direction FSM and synchronized, debounced input with edge pulses
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES = 4,
  parameter int TURN_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic dir_req,
  input  logic dout,
  output logic busy,
  output logic din,
  output logic rise,
  output logic fall,
  output logic gpio_dir,
  output logic gpio_out,
  input  logic gpio_in
);
  typedef enum logic [1:0] {S_IN, S_OUT, S_TURN} state_t;
  localparam int TW = TURN_CYCLES > 0 ? $clog2(TURN_CYCLES + 1) : 1;
  state_t state;
  logic target;
  logic [TW-1:0] tcnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync, chg, freeze, din_prev;
  assign sync = sync_q[SYNC_STAGES-1];
  assign chg = (state != S_TURN) && (dir_req != (state == S_OUT));
  assign freeze = (state == S_TURN) || (chg && TURN_CYCLES > 0);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IN;
      target <= 1'b0;
      tcnt <= '0;
      gpio_dir <= 1'b0;
      busy <= 1'b0;
    end else if (state == S_TURN) begin
      if (dir_req != target) begin
        target <= dir_req;
        tcnt <= TW'(TURN_CYCLES);
      end else if (tcnt == TW'(1)) begin
        state <= target ? S_OUT : S_IN;
        gpio_dir <= target;
        busy <= 1'b0;
      end else begin
        tcnt <= tcnt - 1'b1;
      end
    end else if (chg) begin
      if (TURN_CYCLES > 0) begin
        state <= S_TURN;
        target <= dir_req;
        tcnt <= TW'(TURN_CYCLES);
        gpio_dir <= 1'b0;
        busy <= 1'b1;
      end else begin
        state <= dir_req ? S_OUT : S_IN;
        gpio_dir <= dir_req;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= 1'b0;
      sync_q <= '0;
      din_prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      gpio_out <= dout;
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      din_prev <= din;
      rise <= (state == S_IN) && din && !din_prev;
      fall <= (state == S_IN) && !din && din_prev;
    end
  end
  if (DEB_CYCLES == 0) begin : g_bypass
    assign din = sync;
  end else begin : g_deb
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        din <= 1'b0;
      end else if (freeze || sync == din) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        din <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: vector table, directed debounce/turnaround sequences and randomized model comparison for gpio_pad_ctrl
module tb_gpio_pad_ctrl;
  logic clk = 1'b0, reset = 1'b1, dir_req = 1'b0, dout = 1'b0, gpio_in = 1'b0;
  logic busy0, din0, rise0, fall0, gdir0, gout0;
  logic busy1, din1, rise1, fall1, gdir1, gout1;
  int tests = 0, fails = 0;
  gpio_pad_ctrl u0 (
    .clk(clk), .reset(reset), .dir_req(dir_req), .dout(dout), .busy(busy0), .din(din0),
    .rise(rise0), .fall(fall0), .gpio_dir(gdir0), .gpio_out(gout0), .gpio_in(gpio_in)
  );
  gpio_pad_ctrl #(.SYNC_STAGES(2), .DEB_CYCLES(0), .TURN_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .dir_req(dir_req), .dout(dout), .busy(busy1), .din(din1),
    .rise(rise1), .fall(fall1), .gpio_dir(gdir1), .gpio_out(gout1), .gpio_in(gpio_in)
  );
  always #5 clk = ~clk;
  localparam int M_IN = 0, M_OUT = 1, M_TURN = 2;
  int deb_p[2] = '{4, 0};
  int turn_p[2] = '{3, 0};
  int ms[2] = '{0, 0};
  int msince[2] = '{0, 0};
  logic mtgt[2], mdin[2], mdp[2], mrise[2], mfall[2];
  logic mgout = 1'b0;
  logic [1:0] msync = 2'b00;
  int en = 0;
  bit hs[$], hf[$];
  always @(posedge clk) begin
    logic seen, frz, ok, db;
    en++;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ms[i] = M_IN;
        mdin[i] = 1'b0;
        mdp[i] = 1'b0;
        mrise[i] = 1'b0;
        mfall[i] = 1'b0;
      end
      msync = 2'b00;
      mgout = 1'b0;
      hs.delete();
      hf.delete();
    end else begin
      seen = msync[1];
      msync = {msync[0], gpio_in};
      mgout = dout;
      for (int i = 0; i < 2; i++) begin
        db = mdin[i];
        mrise[i] = ms[i] == M_IN && db && !mdp[i];
        mfall[i] = ms[i] == M_IN && !db && mdp[i];
        mdp[i] = db;
        frz = ms[i] == M_TURN || (turn_p[i] > 0 && dir_req != (ms[i] == M_OUT));
        if (deb_p[i] == 0) begin
          mdin[i] = msync[1];
        end else begin
          hs.push_back(seen);
          hf.push_back(frz);
          if (hs.size() > deb_p[i]) begin
            void'(hs.pop_front());
            void'(hf.pop_front());
          end
          ok = hs.size() == deb_p[i];
          foreach (hs[k]) if (hs[k] == db || hf[k]) ok = 1'b0;
          if (ok) mdin[i] = seen;
        end
        if (ms[i] == M_TURN) begin
          if (dir_req != mtgt[i]) begin
            mtgt[i] = dir_req;
            msince[i] = en;
          end else if (en - msince[i] == turn_p[i]) begin
            ms[i] = mtgt[i] ? M_OUT : M_IN;
          end
        end else if (dir_req != (ms[i] == M_OUT)) begin
          if (turn_p[i] > 0) begin
            ms[i] = M_TURN;
            mtgt[i] = dir_req;
            msince[i] = en;
          end else begin
            ms[i] = dir_req ? M_OUT : M_IN;
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic rst;
    logic dir;
    logic dat;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[16];
  initial begin
    int first0, first1, rise_at, rises, falls, highs;
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 6'b000000},
      '{1'b0, 1'b0, 1'b0, 6'b000000},
      '{1'b0, 1'b1, 1'b0, 6'b010000},
      '{1'b0, 1'b1, 1'b1, 6'b011000},
      '{1'b0, 1'b1, 1'b0, 6'b010000},
      '{1'b0, 1'b1, 1'b1, 6'b101000},
      '{1'b0, 1'b1, 1'b0, 6'b100000},
      '{1'b0, 1'b0, 1'b1, 6'b011000},
      '{1'b0, 1'b0, 1'b0, 6'b010000},
      '{1'b0, 1'b1, 1'b0, 6'b010000},
      '{1'b0, 1'b1, 1'b1, 6'b011000},
      '{1'b0, 1'b1, 1'b0, 6'b010000},
      '{1'b0, 1'b1, 1'b0, 6'b100000},
      '{1'b0, 1'b0, 1'b0, 6'b010000},
      '{1'b1, 1'b0, 1'b1, 6'b000000},
      '{1'b0, 1'b0, 1'b1, 6'b001000}
    };
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst;
      dir_req = tbl[i].dir;
      dout = tbl[i].dat;
      tick();
      chk($sformatf("vec%0d_u0", i), {gdir0, busy0, gout0, din0, rise0, fall0}, tbl[i].exp);
      chk($sformatf("vec%0d_u1", i), {gdir1, busy1, gout1},
          {tbl[i].rst ? 1'b0 : tbl[i].dir, 1'b0, tbl[i].rst ? 1'b0 : tbl[i].dat});
    end
    gpio_in = 1'b1;
    first0 = -1;
    first1 = -1;
    rise_at = -1;
    rises = 0;
    falls = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (din0 && first0 < 0) first0 = c;
      if (din1 && first1 < 0) first1 = c;
      if (rise0 && rise_at < 0) rise_at = c;
      rises += int'(rise0);
      falls += int'(fall0);
    end
    chk("deb_latency", first0, 6);
    chk("bypass_latency", first1, 2);
    chk("rise_cycle", rise_at, 7);
    chk("rise_count", rises, 1);
    chk("fall_none", falls, 0);
    gpio_in = 1'b0;
    falls = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      falls += int'(fall0);
    end
    chk("din_back_low", din0, 1'b0);
    chk("fall_count", falls, 1);
    gpio_in = 1'b1;
    highs = 0;
    rises = 0;
    falls = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 2) gpio_in = 1'b0;
      highs += int'(din0);
      rises += int'(rise0);
      falls += int'(fall0);
    end
    chk("glitch_din", highs, 0);
    chk("glitch_edges", rises + falls, 0);
    for (int c = 0; c < 4000; c++) begin
      reset = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 11) == 0) dir_req = ~dir_req;
      if ($urandom_range(0, 5) == 0) gpio_in = ~gpio_in;
      dout = 1'($urandom);
      tick();
      chk("rand_u0", {gdir0, busy0, gout0, din0, rise0, fall0},
          {ms[0] == M_OUT, ms[0] == M_TURN, mgout, mdin[0], mrise[0], mfall[0]});
      chk("rand_u1", {gdir1, busy1, gout1, din1, rise1, fall1},
          {ms[1] == M_OUT, ms[1] == M_TURN, mgout, mdin[1], mrise[1], mfall[1]});
      chk("rise_fall_excl", rise0 & fall0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
